// File: rtl/op_trans_pkg.sv
`default_nettype none
// ============================================================================
// Module : op_trans_pkg
// Brief  : Shared widths and signed saturation helper for op_trans datapaths.
// Rev    : 1.0  initial release
// ============================================================================
package op_trans_pkg;

   localparam int DEFAULT_WIDTH_OPERAND = 8;
   localparam int SAT_W                 = 64;

   typedef struct packed {
      logic [SAT_W-1:0] value;
      logic             overflow;
   } sat_t;

   // Clamp a sign-extended value into the signed range of 'width' bits.
   function automatic sat_t sat_signed(input logic signed [SAT_W-1:0] value,
                                       input int                      width);
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      sat_t                    r;
      max_v      = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v      = ~max_v;
      r.value    = value;
      r.overflow = 1'b0;
      if (value > max_v) begin
         r.value    = max_v;
         r.overflow = 1'b1;
      end else if (value < min_v) begin
         r.value    = min_v;
         r.overflow = 1'b1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sub_sat_stage.sv
`default_nettype none
// ============================================================================
// Module : sub_sat_stage
// Brief  : Combinational saturate/wrap of a signed value to WIDTH_DIFF bits.
// Rev    : 1.0  initial release
// ============================================================================
module sub_sat_stage
   import op_trans_pkg::*;
#(
   parameter int WIDTH_IN   = 9,
   parameter int WIDTH_DIFF = 8,
   parameter int SATURATE   = 1
) (
   input  logic signed [WIDTH_IN-1:0]   value,
   output logic        [WIDTH_DIFF-1:0] result,
   output logic                         overflow
);

   if (WIDTH_DIFF >= WIDTH_IN) begin : g_extend
      assign result   = WIDTH_DIFF'(value);
      assign overflow = 1'b0;
   end else begin : g_narrow
      logic signed [SAT_W-1:0] ext;
      sat_t                    sat;

      assign ext      = SAT_W'(value);
      assign sat      = sat_signed(ext, WIDTH_DIFF);
      assign overflow = sat.overflow;

      if (SATURATE != 0) begin : g_sat
         assign result = sat.value[WIDTH_DIFF-1:0];
      end else begin : g_wrap
         assign result = value[WIDTH_DIFF-1:0];
      end

      // The clamped value must always be a sign extension of its low bits.
      always_comb begin : p_clamp_range
         assert (sat.value[SAT_W-1:WIDTH_DIFF] ==
                 {(SAT_W-WIDTH_DIFF){sat.value[WIDTH_DIFF-1]}});
      end
   end

endmodule
`default_nettype wire

// File: rtl/sub_pipe.sv
`default_nettype none
// ============================================================================
// Module : sub_pipe
// Brief  : Two-stage signed subtractor with valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module sub_pipe
   import op_trans_pkg::*;
#(
   parameter int WIDTH_OPERAND = DEFAULT_WIDTH_OPERAND,
   parameter int WIDTH_DIFF    = WIDTH_OPERAND,
   parameter int SATURATE      = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH_OPERAND-1:0] minuend,
   input  logic [WIDTH_OPERAND-1:0] subtrahend,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH_DIFF-1:0]    difference,
   output logic                     overflow
);

   localparam int WIDTH_EXACT = WIDTH_OPERAND + 1;

   logic                          s1_valid;
   logic                          s2_valid;
   logic                          s1_adv;
   logic                          s2_adv;
   logic signed [WIDTH_EXACT-1:0] exact;
   logic signed [WIDTH_EXACT-1:0] s1_diff;
   logic        [WIDTH_DIFF-1:0]  sat_result;
   logic                          sat_overflow;

   assign exact = $signed({minuend[WIDTH_OPERAND-1], minuend})
                - $signed({subtrahend[WIDTH_OPERAND-1], subtrahend});

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   sub_sat_stage #(
      .WIDTH_IN   (WIDTH_EXACT),
      .WIDTH_DIFF (WIDTH_DIFF),
      .SATURATE   (SATURATE)
   ) u_sat (
      .value    (s1_diff),
      .result   (sat_result),
      .overflow (sat_overflow)
   );

   // Data registers load only on a valid transfer; empty stages keep stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_diff    <= '0;
         s2_valid   <= 1'b0;
         difference <= '0;
         overflow   <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_diff <= exact;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               difference <= sat_result;
               overflow   <= sat_overflow;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_sub_pipe
// Brief  : Directed self-checking bench for sub_pipe (saturate, wrap, wide).
// Rev    : 1.0  initial release
// ============================================================================
module tb_sub_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] minuend;
   logic [7:0] subtrahend;

   logic       rdy_s, rdy_w, rdy_d;
   logic       vld_s, vld_w, vld_d;
   logic       ovf_s, ovf_w, ovf_d;
   logic [7:0] diff_s, diff_w;
   logic [8:0] diff_d;

   int         n_checks;
   int         n_errors;
   logic [7:0] mon_q[$];
   logic [7:0] exp_stream [4];

   sub_pipe #(.WIDTH_OPERAND(8), .WIDTH_DIFF(8), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
      .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld_s),
      .out_ready(out_ready), .difference(diff_s), .overflow(ovf_s)
   );

   sub_pipe #(.WIDTH_OPERAND(8), .WIDTH_DIFF(8), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w),
      .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld_w),
      .out_ready(out_ready), .difference(diff_w), .overflow(ovf_w)
   );

   sub_pipe #(.WIDTH_OPERAND(8), .WIDTH_DIFF(9), .SATURATE(1)) dut_wide (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d),
      .minuend(minuend), .subtrahend(subtrahend), .out_valid(vld_d),
      .out_ready(out_ready), .difference(diff_d), .overflow(ovf_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && vld_s && out_ready) mon_q.push_back(diff_s);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One isolated transfer through all three variants; entered and left at posedge+1.
   task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic os,
                          input logic [7:0] ew, input logic ow,
                          input logic [8:0] ed, input logic od);
      in_valid   = 1'b1;
      minuend    = a;
      subtrahend = b;
      @(negedge clk);
      check("accept_rdy", 16'(rdy_s), 16'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat1_vld", 16'(vld_s), 16'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat2_vld", 16'(vld_s), 16'd1);
      check("sat_diff", 16'(diff_s), 16'(es));
      check("sat_ovf", 16'(ovf_s), 16'(os));
      check("wrap_vld", 16'(vld_w), 16'd1);
      check("wrap_diff", 16'(diff_w), 16'(ew));
      check("wrap_ovf", 16'(ovf_w), 16'(ow));
      check("wide_vld", 16'(vld_d), 16'd1);
      check("wide_diff", 16'(diff_d), 16'(ed));
      check("wide_ovf", 16'(ovf_d), 16'(od));
      @(posedge clk); #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      minuend    = '0;
      subtrahend = '0;
      exp_stream = '{8'd9, 8'd18, 8'd27, 8'd36};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_vld", 16'(vld_s), 16'd0);
      check("rst_diff", 16'(diff_s), 16'd0);
      check("rst_ovf", 16'(ovf_s), 16'd0);
      check("rst_rdy", 16'(rdy_s), 16'd1);
      @(posedge clk); #1;

      //       a      b      sat        wrap       wide(9)
      run_one(8'h05, 8'h03, 8'h02, 0, 8'h02, 0, 9'h002, 0);
      run_one(8'hF9, 8'h08, 8'hF1, 0, 8'hF1, 0, 9'h1F1, 0);
      run_one(8'h80, 8'h01, 8'h80, 1, 8'h7F, 1, 9'h17F, 0);
      run_one(8'h7F, 8'h80, 8'h7F, 1, 8'hFF, 1, 9'h0FF, 0);
      run_one(8'h00, 8'h80, 8'h7F, 1, 8'h80, 1, 9'h080, 0);
      run_one(8'h7F, 8'hFF, 8'h7F, 1, 8'h80, 1, 9'h080, 0);
      run_one(8'hFF, 8'h7F, 8'h80, 0, 8'h80, 0, 9'h180, 0);

      // Back-to-back stream with a three-cycle downstream stall.
      mon_q.delete();
      in_valid = 1'b1; minuend = 8'd10; subtrahend = 8'd1;
      @(posedge clk); #1;
      minuend = 8'd20; subtrahend = 8'd2;
      @(posedge clk); #1;
      out_ready = 1'b0; minuend = 8'd30; subtrahend = 8'd3;
      repeat (3) begin
         @(negedge clk);
         check("stall_vld", 16'(vld_s), 16'd1);
         check("stall_diff", 16'(diff_s), 16'd9);
         check("stall_rdy", 16'(rdy_s), 16'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("full_drain_rdy", 16'(rdy_s), 16'd1);
      @(posedge clk); #1;
      minuend = 8'd40; subtrahend = 8'd4;
      @(negedge clk);
      check("nobubble_vld", 16'(vld_s), 16'd1);
      check("nobubble_diff", 16'(diff_s), 16'd18);
      check("nobubble_rdy", 16'(rdy_s), 16'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_diff3", 16'(diff_s), 16'd27);
      repeat (2) @(posedge clk);
      #1;
      check("stream_count", 16'(mon_q.size()), 16'd4);
      for (int i = 0; i < 4; i++) check("stream_order", 16'(mon_q[i]), 16'(exp_stream[i]));
      @(negedge clk);
      check("stream_empty", 16'(vld_s), 16'd0);
      @(posedge clk); #1;

      // Asynchronous reset with two items in flight.
      in_valid = 1'b1; minuend = 8'd50; subtrahend = 8'd5;
      @(posedge clk); #1;
      minuend = 8'd60; subtrahend = 8'd6;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("inflight_vld", 16'(vld_s), 16'd1);
      #2 rst = 1'b1;
      #1;
      check("async_vld", 16'(vld_s), 16'd0);
      check("async_diff", 16'(diff_s), 16'd0);
      check("async_ovf", 16'(ovf_s), 16'd0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_vld", 16'(vld_s), 16'd0);
         check("post_rst_rdy", 16'(rdy_s), 16'd1);
      end
      @(posedge clk); #1;
      run_one(8'h07, 8'h02, 8'h05, 0, 8'h05, 0, 9'h005, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
